gcm_ghash_seq: RTL and testbench
================================

Name: gcm_ghash_seq

Overview:
- Sequences the GHASH input stream for one GCM message.
- Takes AAD blocks, then ciphertext blocks, from an upstream valid/ready source and zero-pads the final partial block of each phase.
- Counts byte lengths per phase, then appends the 128-bit length block {len(AAD) in bits, len(CT) in bits}, each field 64-bit big-endian.
- Sits between the AES-CTR/AAD input path and the GHASH multiplier core; one output block per GHASH update.

Parameters:
- LEN_W, 61, width of each per-phase byte counter. Bit length = {count, 3'b0} zero-extended to 64 bits. Legal range 1..61.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a new message; honoured in any state
- has_aad  in  1  sampled with start; 1 = AAD phase present
- has_ct  in  1  sampled with start; 1 = CT phase present
- in_valid  in  1  input block valid
- in_ready  out  1  input block accepted when in_valid && in_ready
- in_data  in  128  block; byte 0 = bits [127:120]
- in_bytes  in  5  valid bytes in in_data, 1..16, MSB-aligned
- in_last  in  1  last block of the current phase
- gh_valid  out  1  GHASH block valid
- gh_ready  in  1  GHASH core accepts block
- gh_block  out  128  padded data block or length block
- gh_is_len  out  1  qualifies gh_block as the length block
- len_aad_bits  out  64  AAD length in bits; final once done
- len_ct_bits  out  64  CT length in bits; final once done
- busy  out  1  high in states AAD, CT, LEN
- done  out  1  one-cycle pulse when the length block is accepted by GHASH
- err  out  1  sticky protocol error; cleared by start or rst

Behaviour:
- Reset: state IDLE. in_ready, gh_valid, gh_is_len, busy, done and err are 0. gh_block, len_aad_bits and len_ct_bits are 0. Both counters are 0.
- FSM states: IDLE, AAD, CT, LEN, DONE.
  - start from any state: counters cleared, output register invalidated (gh_valid=0), err cleared. Next state is AAD if has_aad, else CT if has_ct, else LEN.
  - An abort mid-message is legal; the GHASH core must be cleared by the same start.
- Output register: a single stage. in_ready = (state is AAD or CT) && (!gh_valid || gh_ready). An accepted block appears on gh_block with gh_valid high on the next cycle (latency 1). Throughput is 1 block/cycle when gh_ready is held high.
- gh_valid and gh_block stay stable until gh_ready. Only start or rst may drop them early.
- Padding: bytes at index >= in_bytes are forced to 0.
- Counting: the active phase counter adds in_bytes on acceptance; it wraps modulo 2^LEN_W with no flag.
- Phase transitions:
  - A block accepted with in_last in AAD moves to CT if has_ct, else LEN.
  - A block accepted with in_last in CT moves to LEN.
- LEN state: once the last data block has left the output register (gh_valid=0 or gh_ready that cycle), load gh_block = {len_aad_bits, len_ct_bits} with gh_is_len=1. in_ready stays 0 throughout LEN.
- When the length block is accepted: done pulses for 1 cycle, state goes to DONE, and gh_valid drops. DONE behaves as IDLE, but the len outputs hold their values.
- len_* outputs track the counters combinationally via the shifted count.
- Both phases empty (has_aad=0, has_ct=0): only the length block is issued, gh_block = 128'h0.
- in_valid in IDLE, DONE or LEN: ignored, since in_ready=0.

Optional Feature:
- Macro: GCM_SEQ_ERR_EN.
- Defined: err is set on any of:
  - an accepted block with in_bytes == 0;
  - an accepted block with in_bytes > 16;
  - an accepted block with in_bytes < 16 and in_last = 0.
- An offending block is dropped: no counter update and no output. Once err is set, in_ready is held 0 until start.
- Not defined: err is tied 0. in_bytes of 0 or > 16 is treated as 16. A partial non-last block is passed with padding and counted as-is.

Test Plan:
- start has_aad=1 has_ct=1; AAD 1 block of 16 B; CT 2 blocks (16 B, then 4 B in_last), gh_ready=1 -> 4 outputs: AAD, CT, CT padded to bytes 4..15 = 0, then len block 64'h80 || 64'hA0; done pulses once.
- has_aad=0 has_ct=0 -> single gh_block = 0 with gh_is_len=1; done on acceptance.
- AAD 20 B (16 + 4 last), no CT; gh_ready low for 3 cycles mid-stream -> gh_block stable while stalled; in_ready=0 while stalled; len_aad_bits = 160, len_ct_bits = 0.
- start pulsed during the CT phase with gh_valid high -> gh_valid=0 next cycle, counters 0, new message processed correctly.
- GCM_SEQ_ERR_EN defined: CT block with in_bytes=8 and in_last=0 -> err=1, no output, in_ready=0 until the next start clears err.
- rst asserted for 1 cycle mid-AAD -> all outputs at their reset values next cycle; state IDLE.

Source files
------------

// File: rtl/gcm_ghash_seq.sv
// GCM GHASH input sequencer: pads AAD/CT blocks and appends the length block.
// Optional protocol checking enabled by defining GCM_SEQ_ERR_EN.
module gcm_ghash_seq #(
  parameter int LEN_W = 61
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         has_aad,
  input  logic         has_ct,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [4:0]   in_bytes,
  input  logic         in_last,
  output logic         gh_valid,
  input  logic         gh_ready,
  output logic [127:0] gh_block,
  output logic         gh_is_len,
  output logic [63:0]  len_aad_bits,
  output logic [63:0]  len_ct_bits,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE, S_AAD, S_CT, S_LEN, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               has_ct_q, has_ct_d;
  logic [LEN_W-1:0]   cnt_aad_q, cnt_aad_d;
  logic [LEN_W-1:0]   cnt_ct_q, cnt_ct_d;
  logic               vld_q, vld_d;
  logic [127:0]       blk_q, blk_d;
  logic               is_len_q, is_len_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [4:0]         nb;
  logic               bad;
  logic [127:0]       padded;
  logic               out_free;
  logic               acc;

  always_comb begin
    nb  = in_bytes;
    bad = 1'b0;
`ifdef GCM_SEQ_ERR_EN
    bad = (in_bytes == 5'd0) || (in_bytes > 5'd16) ||
          ((in_bytes < 5'd16) && !in_last);
`else
    if ((in_bytes == 5'd0) || (in_bytes > 5'd16))
      nb = 5'd16;
`endif
    padded = '0;
    for (int i = 0; i < 16; i++)
      if (5'(i) < nb)
        padded[127-8*i -: 8] = in_data[127-8*i -: 8];
  end

  assign out_free = !vld_q || gh_ready;
  assign in_ready = ((state_q == S_AAD) || (state_q == S_CT)) &&
                    out_free && !err_q;
  assign acc      = in_valid && in_ready;

  assign len_aad_bits = 64'({cnt_aad_q, 3'b000});
  assign len_ct_bits  = 64'({cnt_ct_q, 3'b000});

  assign gh_valid  = vld_q;
  assign gh_block  = blk_q;
  assign gh_is_len = is_len_q;
  assign busy      = (state_q == S_AAD) || (state_q == S_CT) ||
                     (state_q == S_LEN);
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d   = state_q;
    has_ct_d  = has_ct_q;
    cnt_aad_d = cnt_aad_q;
    cnt_ct_d  = cnt_ct_q;
    vld_d     = vld_q;
    blk_d     = blk_q;
    is_len_d  = is_len_q;
    done_d    = 1'b0;
    err_d     = err_q;

    if (vld_q && gh_ready) begin
      vld_d    = 1'b0;
      is_len_d = 1'b0;
    end

    unique case (state_q)
      S_AAD, S_CT: begin
        if (acc) begin
          if (bad) begin
            err_d = 1'b1;
          end else begin
            vld_d    = 1'b1;
            blk_d    = padded;
            is_len_d = 1'b0;
            if (state_q == S_AAD)
              cnt_aad_d = cnt_aad_q + LEN_W'(nb);
            else
              cnt_ct_d = cnt_ct_q + LEN_W'(nb);
            if (in_last)
              state_d = (state_q == S_AAD && has_ct_q) ? S_CT : S_LEN;
          end
        end
      end
      S_LEN: begin
        // Length block goes out only after the last data block has left.
        if (vld_q && is_len_q) begin
          if (gh_ready) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else if (out_free) begin
          vld_d    = 1'b1;
          blk_d    = {len_aad_bits, len_ct_bits};
          is_len_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (start) begin
      cnt_aad_d = '0;
      cnt_ct_d  = '0;
      vld_d     = 1'b0;
      is_len_d  = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      has_ct_d  = has_ct;
      state_d   = has_aad ? S_AAD : (has_ct ? S_CT : S_LEN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      has_ct_q  <= 1'b0;
      cnt_aad_q <= '0;
      cnt_ct_q  <= '0;
      vld_q     <= 1'b0;
      blk_q     <= '0;
      is_len_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      has_ct_q  <= has_ct_d;
      cnt_aad_q <= cnt_aad_d;
      cnt_ct_q  <= cnt_ct_d;
      vld_q     <= vld_d;
      blk_q     <= blk_d;
      is_len_q  <= is_len_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_gcm_ghash_seq.sv
// Randomized bench for gcm_ghash_seq against a message-level reference model.
// Protocol-error scenario runs only when GCM_SEQ_ERR_EN is defined.
module tb_gcm_ghash_seq;

  logic         clk = 1'b0;
  logic         rst, start, has_aad, has_ct, in_valid, in_last, gh_ready;
  logic [127:0] in_data;
  logic [4:0]   in_bytes;
  logic         in_ready, gh_valid, gh_is_len, busy, done, err;
  logic [127:0] gh_block;
  logic [63:0]  len_aad_bits, len_ct_bits;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] d;
    int           n;
    bit           last;
  } blk_t;

  blk_t aad_q[$];
  blk_t ct_q[$];

  gcm_ghash_seq dut (
    .clk(clk), .rst(rst), .start(start), .has_aad(has_aad),
    .has_ct(has_ct), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_bytes(in_bytes), .in_last(in_last),
    .gh_valid(gh_valid), .gh_ready(gh_ready), .gh_block(gh_block),
    .gh_is_len(gh_is_len), .len_aad_bits(len_aad_bits),
    .len_ct_bits(len_ct_bits), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Keep the first n bytes (MSB first) of a block.
  function automatic logic [127:0] pad(logic [127:0] d, int n);
    logic [127:0] m;
    m = ~128'h0;
    m = m << (8 * (16 - n));
    return d & m;
  endfunction

  task automatic mk(input bit to_ct, input int nfull, input int lastn);
    blk_t b;
    for (int i = 0; i <= nfull; i++) begin
      b.d    = rnd128();
      b.n    = (i == nfull) ? lastn : 16;
      b.last = (i == nfull);
      if (to_ct) ct_q.push_back(b);
      else aad_q.push_back(b);
    end
  endtask

  task automatic pulse_start(input bit ha, input bit hc);
    @(negedge clk);
    start = 1'b1; has_aad = ha; has_ct = hc; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (gh_valid !== 1'b0 || len_aad_bits !== 64'h0 ||
        len_ct_bits !== 64'h0 || busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL start_state: vld=%b la=%h lc=%h busy=%b err=%b want 0 0 0 1 0",
               gh_valid, len_aad_bits, len_ct_bits, busy, err);
    end
  endtask

  // Streams the queued phases and checks every GHASH output in order.
  task automatic run_body(input bit ha, input bit hc, input int stall);
    blk_t         ins[$];
    logic [128:0] exp_q[$];
    logic [128:0] e;
    longint       sa, sc;
    int           k;
    bit           fin, held;
    logic [127:0] held_blk;
    sa = 0; sc = 0; k = 0; fin = 0; held = 0; held_blk = '0;
    if (ha) foreach (aad_q[i]) begin
      ins.push_back(aad_q[i]);
      exp_q.push_back({1'b0, pad(aad_q[i].d, aad_q[i].n)});
      sa += aad_q[i].n;
    end
    if (hc) foreach (ct_q[i]) begin
      ins.push_back(ct_q[i]);
      exp_q.push_back({1'b0, pad(ct_q[i].d, ct_q[i].n)});
      sc += ct_q[i].n;
    end
    exp_q.push_back({1'b1, 64'(sa * 8), 64'(sc * 8)});
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      @(negedge clk);
      gh_ready = ($urandom_range(0, 99) >= stall);
      if (k < ins.size()) begin
        in_valid = 1'b1;
        in_data  = ins[k].d;
        in_bytes = 5'(ins[k].n);
        in_last  = ins[k].last;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held) begin
        checks++;
        if (gh_valid !== 1'b1 || gh_block !== held_blk) begin
          errors++;
          $display("FAIL stall_hold: vld=%b blk=%h want 1 %h",
                   gh_valid, gh_block, held_blk);
        end
      end
      if (gh_valid && !gh_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_ready: in_ready=%b want 0", in_ready);
        end
      end
      if (done) begin
        checks++; errors++;
        $display("FAIL early_done: done=%b want 0", done);
      end
      if (in_valid && in_ready) k++;
      if (gh_valid && gh_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_out: blk=%h want none", gh_block);
        end else begin
          e = exp_q.pop_front();
          if ({gh_is_len, gh_block} !== e) begin
            errors++;
            $display("FAIL out_blk: len=%b blk=%h want %b %h",
                     gh_is_len, gh_block, e[128], e[127:0]);
          end
          if (e[128]) fin = 1;
        end
      end
      held     = gh_valid && !gh_ready;
      held_blk = gh_block;
    end
    in_valid = 1'b0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL timeout: outputs_left=%0d want 0", exp_q.size());
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || gh_valid !== 1'b0 ||
        len_aad_bits !== 64'(sa * 8) || len_ct_bits !== 64'(sc * 8)) begin
      errors++;
      $display("FAIL done_state: done=%b busy=%b vld=%b la=%0d lc=%0d want 1 0 0 %0d %0d",
               done, busy, gh_valid, len_aad_bits, len_ct_bits, sa * 8, sc * 8);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || len_aad_bits !== 64'(sa * 8)) begin
      errors++;
      $display("FAIL done_pulse: done=%b la=%0d want 0 %0d",
               done, len_aad_bits, sa * 8);
    end
  endtask

  task automatic run_msg(input bit ha, input bit hc, input int stall);
    pulse_start(ha, hc);
    run_body(ha, hc, stall);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; has_aad = 1'b0; has_ct = 1'b0;
    in_valid = 1'b0; in_data = '0; in_bytes = 5'd16; in_last = 1'b0;
    gh_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, gh_valid, gh_is_len, busy, done, err} !== 6'b0 ||
        gh_block !== 128'h0 || len_aad_bits !== 64'h0 ||
        len_ct_bits !== 64'h0) begin
      errors++;
      $display("FAIL reset: flags=%b blk=%h la=%h lc=%h want 0",
               {in_ready, gh_valid, gh_is_len, busy, done, err},
               gh_block, len_aad_bits, len_ct_bits);
    end
  endtask

  task automatic test_basic();
    aad_q.delete(); ct_q.delete();
    mk(0, 0, 16);
    mk(1, 1, 4);
    run_msg(1, 1, 0);
    checks++;
    if (len_aad_bits !== 64'h80 || len_ct_bits !== 64'hA0) begin
      errors++;
      $display("FAIL basic_len: la=%h lc=%h want 80 a0",
               len_aad_bits, len_ct_bits);
    end
  endtask

  task automatic test_empty();
    aad_q.delete(); ct_q.delete();
    run_msg(0, 0, 30);
  endtask

  task automatic test_stall();
    aad_q.delete(); ct_q.delete();
    mk(0, 1, 4);
    run_msg(1, 0, 60);
    checks++;
    if (len_aad_bits !== 64'd160 || len_ct_bits !== 64'd0) begin
      errors++;
      $display("FAIL stall_len: la=%0d lc=%0d want 160 0",
               len_aad_bits, len_ct_bits);
    end
  endtask

  task automatic test_random();
    bit ha, hc;
    for (int m = 0; m < 10; m++) begin
      aad_q.delete(); ct_q.delete();
      ha = 1'($urandom_range(0, 1));
      hc = 1'($urandom_range(0, 1));
      if (ha) mk(0, $urandom_range(0, 3), $urandom_range(1, 16));
      if (hc) mk(1, $urandom_range(0, 4), $urandom_range(1, 16));
      run_msg(ha, hc, $urandom_range(0, 50));
    end
  endtask

  task automatic test_abort();
    pulse_start(1, 1);
    @(negedge clk);
    gh_ready = 1'b1; in_valid = 1'b1; in_data = rnd128();
    in_bytes = 5'd16; in_last = 1'b1;
    @(negedge clk);
    in_data = rnd128(); in_last = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; gh_ready = 1'b0;
    #1;
    checks++;
    if (gh_valid !== 1'b1 || len_ct_bits !== 64'd128) begin
      errors++;
      $display("FAIL abort_pre: vld=%b lc=%0d want 1 128",
               gh_valid, len_ct_bits);
    end
    aad_q.delete(); ct_q.delete();
    mk(1, 2, 7);
    pulse_start(0, 1);
    run_body(0, 1, 20);
  endtask

  task automatic test_rst_mid();
    pulse_start(1, 0);
    @(negedge clk);
    gh_ready = 1'b1; in_valid = 1'b1; in_data = rnd128();
    in_bytes = 5'd16; in_last = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, gh_valid, gh_is_len, busy, done, err} !== 6'b0 ||
        gh_block !== 128'h0 || len_aad_bits !== 64'h0) begin
      errors++;
      $display("FAIL rst_mid: flags=%b blk=%h la=%h want 0",
               {in_ready, gh_valid, gh_is_len, busy, done, err},
               gh_block, len_aad_bits);
    end
    in_valid = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || gh_valid !== 1'b0 || len_aad_bits !== 64'h0) begin
      errors++;
      $display("FAIL idle_ignore: rdy=%b vld=%b la=%h want 0 0 0",
               in_ready, gh_valid, len_aad_bits);
    end
    in_valid = 1'b0;
  endtask

`ifdef GCM_SEQ_ERR_EN
  task automatic test_err();
    pulse_start(0, 1);
    @(negedge clk);
    gh_ready = 1'b1; in_valid = 1'b1; in_data = rnd128();
    in_bytes = 5'd8; in_last = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (err !== 1'b1 || gh_valid !== 1'b0 || in_ready !== 1'b0 ||
        len_ct_bits !== 64'h0) begin
      errors++;
      $display("FAIL err_set: err=%b vld=%b rdy=%b lc=%h want 1 0 0 0",
               err, gh_valid, in_ready, len_ct_bits);
    end
    aad_q.delete(); ct_q.delete();
    mk(1, 0, 16);
    run_msg(0, 1, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_stall();
    test_random();
    test_abort();
    test_rst_mid();
`ifdef GCM_SEQ_ERR_EN
    test_err();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
